// File: rtl/fifo_8bits_pkg.sv
// Shared sizing defaults for the lane FIFO, also used by the demux and the four-lane wrapper.
package fifo_8bits_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;

  // Net occupancy change implied by the accepted write/read pair in a cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

endpackage

// File: rtl/fifo_8bits_mem.sv
// DEPTH x DATA_W register array with one write port and one registered read port.
module mem_2p_8bits
  import fifo_8bits_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [(1 << ADDR_W)];
  logic [DATA_W-1:0] rd_data_r;

  // Storage write; the array is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register holds its last word between accepted reads.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_8bits.sv
// Per-lane synchronous byte FIFO with occupancy count, threshold flags and sticky overflow error.
module fifo_8bits
  import fifo_8bits_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [ADDR_W:0]   umbral_alto,
  input  logic [ADDR_W:0]   umbral_bajo,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE_C = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE_C = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              valid_r;
  logic              error_r;
  logic              full_s;
  logic              empty_s;
  logic              wr_en_s;
  logic              rd_en_s;
  cnt_op_e           cnt_op_s;

  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == {(ADDR_W+1){1'b0}});

  // Accept decode: a pop frees a slot so push-at-full still lands; no bypass when empty.
  always_comb begin
    rd_en_s  = pop && !empty_s;
    wr_en_s  = push && (!full_s || rd_en_s);
    cnt_op_s = cnt_op_e'({wr_en_s, rd_en_s});
  end

  // Pointers, occupancy, read-valid pulse and sticky overflow.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {(ADDR_W+1){1'b0}};
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case (cnt_op_s)
        CNT_INC: count_r <= count_r + CNT_ONE_C;
        CNT_DEC: count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
      valid_r <= rd_en_s;
      error_r <= error_r | (push && !wr_en_s);
    end
  end

  mem_2p_8bits #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_en   (rd_en_s),
    .rd_addr (rd_ptr_r),
    .rd_data (data_out)
  );

  assign valid_out    = valid_r;
  assign error        = error_r;
  assign count        = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= umbral_alto);
  assign almost_empty = (count_r <= umbral_bajo);

endmodule

// File: tb/tb_fifo_8bits.sv
// Directed bench for fifo_8bits: queue-based reference model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_fifo_8bits;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       push = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       pop = 1'b0;
  logic [3:0] umbral_alto = 4'd6;
  logic [3:0] umbral_bajo = 4'd1;
  logic [7:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty, error;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  fifo_8bits dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .error(error), .count(count)
  );

  always #20 clk = ~clk;

  // Reference model: a plain queue of at most 8 bytes.
  byte unsigned q[$];
  logic [7:0]   m_dout = 8'h00;
  logic         m_valid = 1'b0;
  logic         m_err = 1'b0;
  bit           m_rd, m_wr;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q.delete();
      m_dout  = 8'h00;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      m_rd = pop && (q.size() > 0);
      m_wr = push && ((q.size() < 8) || m_rd);
      m_valid = m_rd;
      if (m_rd) m_dout = q.pop_front();
      if (m_wr) q.push_back(data_in);
      if (push && !m_wr) m_err = 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_count", int'(count), q.size());
    chk("m_full", int'(full), int'(q.size() == 8));
    chk("m_empty", int'(empty), int'(q.size() == 0));
    chk("m_afull", int'(almost_full), int'(q.size() >= int'(umbral_alto)));
    chk("m_aempty", int'(almost_empty), int'(q.size() <= int'(umbral_bajo)));
    chk("m_valid", int'(valid_out), int'(m_valid));
    chk("m_error", int'(error), int'(m_err));
    chk("m_dout", int'(data_out), int'(m_dout));
  end

  task automatic cyc(input logic p, input logic [7:0] d, input logic po);
    push = p;
    data_in = d;
    pop = po;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
  endtask

  initial begin
    // 1: reset state
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_aempty", int'(almost_empty), 1);

    // 2: fill then drain in order
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 4) chk("fill_afull_lo", int'(almost_full), 0);
      if (i == 5) chk("fill_afull_hi", int'(almost_full), 1);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_valid", int'(valid_out), 1);
      chk("drain_data", int'(data_out), i);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("drain_vlow", int'(valid_out), 0);
    chk("drain_empty", int'(empty), 1);

    // 3: overflow drops the word and sets sticky error
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf_error", int'(error), 1);
    chk("ovf_count", int'(count), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("ovf_data", int'(data_out), i);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", int'(error), 1);
    chk("ovf_empty", int'(empty), 1);

    // 4: simultaneous push+pop at count 4 across pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(8'h24 + i), 1'b1);
      chk("sim_data", int'(data_out), 8'h20 + i);
      chk("sim_count", int'(count), 4);
    end
    chk("sim_error", int'(error), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("sim_tail", int'(data_out), 8'h2A + i);
    end
    cyc(1'b0, 8'h00, 1'b0);

    // thresholds act immediately
    umbral_alto = 4'd0;
    #1 chk("thr_afull0", int'(almost_full), 1);
    umbral_alto = 4'd6;
    umbral_bajo = 4'd8;
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    chk("thr_aempty8", int'(almost_empty), 1);
    umbral_bajo = 4'd1;
    #1 chk("thr_aempty1", int'(almost_empty), 0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // 5: empty edge cases
    cyc(1'b0, 8'h00, 1'b1);
    chk("emp_pop_valid", int'(valid_out), 0);
    chk("emp_pop_count", int'(count), 0);
    cyc(1'b1, 8'h5C, 1'b1);
    chk("emp_pp_count", int'(count), 1);
    chk("emp_pp_valid", int'(valid_out), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("emp_5c", int'(data_out), 8'h5C);
    chk("emp_5c_valid", int'(valid_out), 1);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    cyc(1'b1, 8'h44, 1'b1);
    chk("arst_pre_count", int'(count), 4);
    cyc(1'b1, 8'h45, 1'b0);
    chk("arst_pre5", int'(count), 5);
    push = 1'b0;
    #5 reset_L = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_dout", int'(data_out), 0);
    chk("arst_valid", int'(valid_out), 0);
    #3 reset_L = 1'b1;
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("arst_11", int'(data_out), 8'h11);
    chk("arst_11_valid", int'(valid_out), 1);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
